icache_refill: RTL and testbench



---
 rtl/icache_refill.sv | 170 +++++++++++++++++
 tb/tb_icache_refill.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction cache line refill controller (2-way set associative, 2-word lines).
// On an accepted miss it requests the line, collects two beats, writes the victim
// way's tag/valid and data arrays, and reports the requested word.
// Optional build macro ICACHE_CRITICAL_FWD_EN: forwards the requested word one cycle
// after its beat arrives. When undefined, fwd_valid_o/fwd_word_o are tied to 0.
//
// state | meaning
// IDLE  | ready for a miss
// REQ   | line read request held until granted
// RECV  | collecting two beats
// WRITE | one-cycle array write into the victim way
// DONE  | one-cycle refill_done pulse
module icache_refill #(
    parameter int TAG_WIDTH   = 25,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   miss_valid_i,
    input  logic [31:0]            miss_addr_i,
    output logic                   miss_ready_o,
    output logic                   mem_rreq_o,
    output logic [31:0]            mem_raddr_o,
    input  logic                   mem_rgnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   hit_valid_i,
    input  logic [INDEX_WIDTH-1:0] hit_index_i,
    input  logic                   hit_way_i,
    output logic [1:0]             tagv_we_o,
    output logic [INDEX_WIDTH-1:0] tagv_waddr_o,
    output logic [TAG_WIDTH-1:0]   tagv_wdata_o,
    output logic [1:0]             data_we_o,
    output logic [INDEX_WIDTH-1:0] data_waddr_o,
    output logic [63:0]            data_wline_o,
    output logic                   refill_done_o,
    output logic [31:0]            refill_word_o,
    output logic                   fwd_valid_o,
    output logic [31:0]            fwd_word_o
);

    localparam int NSETS = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [31:2]            addr_q;
    logic                   victim_q;
    logic                   cnt_q;
    logic [31:0]            word0_q, word1_q;
    logic [NSETS-1:0]       lru_q;

    logic                   accept;
    logic                   beat;
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   unused_addr_lsbs;

    assign accept           = miss_valid_i && (state_q == IDLE);
    assign beat             = mem_rvalid_i && (state_q == RECV);
    assign idx              = addr_q[INDEX_WIDTH+2:3];
    assign tag              = addr_q[31:32-TAG_WIDTH];
    assign unused_addr_lsbs = ^miss_addr_i[1:0];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_valid_i) state_d = REQ;
            REQ:     if (mem_rgnt_i) state_d = RECV;
            RECV:    if (mem_rvalid_i && cnt_q) state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; data fields are zero outside their own state
    always_comb begin
        miss_ready_o  = 1'b0;
        mem_rreq_o    = 1'b0;
        mem_raddr_o   = '0;
        tagv_we_o     = '0;
        tagv_waddr_o  = '0;
        tagv_wdata_o  = '0;
        data_we_o     = '0;
        data_waddr_o  = '0;
        data_wline_o  = '0;
        refill_done_o = 1'b0;
        refill_word_o = '0;
        case (state_q)
            IDLE: miss_ready_o = 1'b1;
            REQ: begin
                mem_rreq_o  = 1'b1;
                mem_raddr_o = {addr_q[31:3], 3'b000};
            end
            WRITE: begin
                tagv_we_o    = victim_q ? 2'b10 : 2'b01;
                data_we_o    = victim_q ? 2'b10 : 2'b01;
                tagv_waddr_o = idx;
                data_waddr_o = idx;
                tagv_wdata_o = tag;
                data_wline_o = {word1_q, word0_q};
            end
            DONE: begin
                refill_done_o = 1'b1;
                refill_word_o = addr_q[2] ? word1_q : word0_q;
            end
            default: ;
        endcase
    end

    // Miss capture and beat collection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            victim_q <= 1'b0;
            cnt_q    <= 1'b0;
            word0_q  <= '0;
            word1_q  <= '0;
        end else if (accept) begin
            addr_q   <= miss_addr_i[31:2];
            victim_q <= lru_q[miss_addr_i[INDEX_WIDTH+2:3]];
            cnt_q    <= 1'b0;
        end else if (beat) begin
            if (cnt_q) word1_q <= mem_rdata_i;
            else       word0_q <= mem_rdata_i;
            cnt_q <= ~cnt_q;
        end
    end

    // LRU bits: a refill write overrides a hit update to the same set
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lru_q <= '0;
        end else begin
            if (hit_valid_i)       lru_q[hit_index_i] <= ~hit_way_i;
            if (state_q == WRITE)  lru_q[idx]         <= ~victim_q;
        end
    end

`ifdef ICACHE_CRITICAL_FWD_EN
    logic        fwd_valid_q;
    logic [31:0] fwd_word_q;

    // Critical word forward, one cycle after the requested beat is captured
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd_valid_q <= 1'b0;
            fwd_word_q  <= '0;
        end else begin
            fwd_valid_q <= beat && (cnt_q == addr_q[2]);
            if (beat && (cnt_q == addr_q[2])) fwd_word_q <= mem_rdata_i;
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_word_o  = fwd_word_q;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_word_o  = '0;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed testbench for icache_refill: each miss is driven through a small memory
// responder with configurable grant delay and inter-beat gap.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rstn;
    logic        miss_valid, miss_ready;
    logic [31:0] miss_addr;
    logic        mem_rreq, mem_rgnt, mem_rvalid;
    logic [31:0] mem_raddr, mem_rdata;
    logic        hit_valid, hit_way;
    logic [3:0]  hit_index;
    logic [1:0]  tagv_we, data_we;
    logic [3:0]  tagv_waddr, data_waddr;
    logic [24:0] tagv_wdata;
    logic [63:0] data_wline;
    logic        refill_done, fwd_valid;
    logic [31:0] refill_word, fwd_word;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk(clk), .rstn(rstn),
        .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
        .mem_rreq_o(mem_rreq), .mem_raddr_o(mem_raddr),
        .mem_rgnt_i(mem_rgnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .hit_valid_i(hit_valid), .hit_index_i(hit_index), .hit_way_i(hit_way),
        .tagv_we_o(tagv_we), .tagv_waddr_o(tagv_waddr), .tagv_wdata_o(tagv_wdata),
        .data_we_o(data_we), .data_waddr_o(data_waddr), .data_wline_o(data_wline),
        .refill_done_o(refill_done), .refill_word_o(refill_word),
        .fwd_valid_o(fwd_valid), .fwd_word_o(fwd_word)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " miss_ready"},  miss_ready, 1);
        check({nm, " mem_rreq"},    mem_rreq, 0);
        check({nm, " mem_raddr"},   mem_raddr, 0);
        check({nm, " tagv_we"},     tagv_we, 0);
        check({nm, " data_we"},     data_we, 0);
        check({nm, " refill_done"}, refill_done, 0);
        check({nm, " fwd_valid"},   fwd_valid, 0);
        check({nm, " data_outs"},   {refill_word, fwd_word}, 0);
        check({nm, " wr_fields"},   {tagv_waddr, data_waddr, tagv_wdata, data_wline[31:0]}, 0);
    endtask

    // One full refill. Expected address/tag/index/way are hand-computed by the caller;
    // latency is 4 cycles plus grant wait plus beat gap.
    task automatic run_miss(input string nm, input logic [31:0] addr,
                            input int gdly, input int gap, input bit junk, input bit hit_in_write,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] exp_raddr, input logic [3:0] exp_idx,
                            input logic [24:0] exp_tag, input logic [1:0] exp_way,
                            input logic [31:0] exp_word);
        int cyc = 0, rreq_n = 0, wait_n = 0, wr_n = 0, fwd_n = 0, p = 0;
        int done_cyc = -1, fwd_cyc = -1, bcyc0 = -1, bcyc1 = -1;
        bit granted = 0, done_seen = 0, raddr_bad = 0, ready_bad = 0, we_bad = 0;
        logic [1:0]  wr_we = '0;
        logic [3:0]  wr_idx = '0, wr_didx = '0;
        logic [24:0] wr_tag = '0;
        logic [63:0] wr_line = '0;
        logic [31:0] done_w = '0, fwd_w = '0;

        @(negedge clk);
        check({nm, " ready_before"}, miss_ready, 1);
        miss_valid = 1'b1;
        miss_addr  = addr;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_addr  = '0;
        while (!done_seen && cyc < 60) begin
            if (mem_rreq) begin
                rreq_n++;
                if (mem_raddr !== exp_raddr) raddr_bad = 1;
            end
            if (miss_ready) ready_bad = 1;
            if (data_we !== tagv_we) we_bad = 1;
            if (tagv_we != 2'b00) begin
                wr_n++;
                wr_we = tagv_we; wr_idx = tagv_waddr; wr_didx = data_waddr;
                wr_tag = tagv_wdata; wr_line = data_wline;
            end
            if (fwd_valid) begin
                fwd_n++; fwd_cyc = cyc; fwd_w = fwd_word;
            end
            if (refill_done) begin
                done_seen = 1; done_cyc = cyc; done_w = refill_word;
            end
            mem_rgnt = 0; mem_rvalid = 0; mem_rdata = '0; hit_valid = 0;
            if (mem_rreq) begin
                if (wait_n == gdly) begin
                    mem_rgnt = 1; granted = 1;
                end
                wait_n++;
                if (junk) begin
                    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
                end
            end else if (granted) begin
                if (p == 0) begin
                    mem_rvalid = 1; mem_rdata = b0; bcyc0 = cyc;
                end else if (p == 1 + gap) begin
                    mem_rvalid = 1; mem_rdata = b1; bcyc1 = cyc;
                end
                p++;
            end
            if (hit_in_write && tagv_we != 2'b00) begin
                hit_valid = 1; hit_index = exp_idx; hit_way = 1;
            end
            @(negedge clk);
            cyc++;
        end
        check({nm, " done_seen"},   done_seen, 1);
        check({nm, " latency"},     done_cyc, 4 + gdly + gap);
        check({nm, " refill_word"}, done_w, exp_word);
        check({nm, " rreq_cycles"}, rreq_n, gdly + 1);
        check({nm, " raddr_bad"},   raddr_bad, 0);
        check({nm, " ready_low"},   ready_bad, 0);
        check({nm, " write_count"}, wr_n, 1);
        check({nm, " we_match"},    we_bad, 0);
        check({nm, " tagv_we"},     wr_we, exp_way);
        check({nm, " waddr"},       {wr_idx, wr_didx}, {exp_idx, exp_idx});
        check({nm, " tag"},         wr_tag, exp_tag);
        check({nm, " wline"},       wr_line, {b1, b0});
`ifdef ICACHE_CRITICAL_FWD_EN
        check({nm, " fwd_count"},   fwd_n, 1);
        check({nm, " fwd_cycle"},   fwd_cyc, (addr[2] ? bcyc1 : bcyc0) + 1);
        check({nm, " fwd_word"},    fwd_w, exp_word);
`else
        check({nm, " fwd_count"},   fwd_n, 0);
        check({nm, " fwd_tie"},     {fwd_cyc, fwd_w}, {32'hFFFF_FFFF, 32'h0});
`endif
        check({nm, " ready_after"}, miss_ready, 1);
        check({nm, " done_pulse"},  refill_done, 0);
    endtask

    initial begin
        rstn = 0; miss_valid = 0; miss_addr = '0;
        mem_rgnt = 0; mem_rvalid = 0; mem_rdata = '0;
        hit_valid = 0; hit_index = '0; hit_way = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1;

        run_miss("t1", 32'h0000_0034, 0, 0, 0, 0, 32'hAAAA_0000, 32'hBBBB_0001,
                 32'h0000_0030, 4'd6, 25'h0, 2'b01, 32'hBBBB_0001);
        run_miss("t2", 32'h8000_0030, 2, 0, 1, 0, 32'hCCCC_0002, 32'hDDDD_0003,
                 32'h8000_0030, 4'd6, 25'h100_0000, 2'b10, 32'hCCCC_0002);

        @(negedge clk);
        hit_valid = 1; hit_index = 4'd3; hit_way = 0;
        @(negedge clk);
        hit_valid = 0;
        run_miss("t3", 32'h0000_0018, 0, 0, 0, 0, 32'h1111_0000, 32'h2222_0001,
                 32'h0000_0018, 4'd3, 25'h0, 2'b10, 32'h1111_0000);

        run_miss("t4", 32'h0000_1234, 0, 0, 0, 1, 32'h0123_4567, 32'h89AB_CDEF,
                 32'h0000_1230, 4'd6, 25'h24, 2'b01, 32'h89AB_CDEF);
        run_miss("t5", 32'h0000_0030, 0, 0, 0, 0, 32'h5555_0000, 32'h6666_0001,
                 32'h0000_0030, 4'd6, 25'h0, 2'b10, 32'h5555_0000);

        run_miss("t6", 32'h0000_0FFC, 5, 1, 1, 0, 32'h7777_0000, 32'h8888_0001,
                 32'h0000_0FF8, 4'd15, 25'h1F, 2'b01, 32'h8888_0001);

        // Reset after the first beat; lru[15] is 1 here, so way 0 afterwards shows lru was cleared
        @(negedge clk);
        miss_valid = 1; miss_addr = 32'h0000_0FF8;
        @(negedge clk);
        miss_valid = 0; miss_addr = '0;
        check("rst_mid req", mem_rreq, 1);
        mem_rgnt = 1;
        @(negedge clk);
        mem_rgnt = 0; mem_rvalid = 1; mem_rdata = 32'h9999_0000;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0;
        check("rst_mid recv_we", tagv_we, 0);
        rstn = 0;
        #1;
        check_idle_outputs("rst_mid async");
        @(negedge clk);
        check_idle_outputs("rst_mid held");
        rstn = 1;
        run_miss("t7", 32'h0000_0FF8, 0, 0, 0, 0, 32'hABCD_0000, 32'hEF01_0001,
                 32'h0000_0FF8, 4'd15, 25'h1F, 2'b01, 32'hABCD_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
